// File: rtl/fetch_sequencer_pkg.sv
// Shared opcode/funct constants, FSM state type and branch-offset helper for the fetch side.
package fetch_sequencer_pkg;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpJal   = 6'h03;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [5:0] FnJr      = 6'h08;
  localparam logic [5:0] FnSyscall = 6'h0C;
  localparam logic [5:0] FnAdd     = 6'h20;
  localparam logic [5:0] FnSub     = 6'h22;
  localparam logic [5:0] FnSlt     = 6'h2A;

  typedef enum logic [1:0] {
    StFetch,
    StReq,
    StIssue,
    StHalt
  } fetch_state_e;

  // Sign-extended word offset of a branch immediate.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/acknowledge bus between the fetch sequencer and imem.
interface fetch_sequencer_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Combinational next-PC selection for the retiring instruction: JR, J/JAL, taken BNE, or pc+4.
module fetch_sequencer_next_pc_calc
  import fetch_sequencer_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [25:0] i_instr_index,
  input  logic        i_jump,
  input  logic        i_jump_sel,
  input  logic        i_branch,
  input  logic        i_branch_taken,
  input  logic [31:0] i_jr_target,
  output logic [31:0] o_pc4,
  output logic [31:0] o_next_pc,
  output logic        o_misalign
);

  assign o_pc4 = i_pc + 32'd4;

  // Jump outranks Branch when control raises both.
  always_comb begin
    o_next_pc = o_pc4;
    if (i_jump && i_jump_sel) begin
      o_next_pc = i_jr_target;
    end else if (i_jump) begin
      o_next_pc = {o_pc4[31:28], i_instr_index, 2'b00};
    end else if (i_branch && i_branch_taken) begin
      o_next_pc = o_pc4 + branch_offset(i_instr_index[15:0]);
    end
  end

  assign o_misalign = i_jump & i_jump_sel & (|i_jr_target[1:0]);

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch sequencer: owns PC and IR, fetches over req/ack, issues fields, halts on
// SYSCALL, misaligned JR target or imem timeout.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DefaultResetPc,
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  fetch_sequencer_if.master        imem,
  output logic                     issue_valid,
  output logic [5:0]               opcode,
  output logic [5:0]               funct,
  output logic [4:0]               rs,
  output logic [4:0]               rt,
  output logic [4:0]               rd,
  output logic [15:0]              imm16,
  output logic [31:0]              link_pc,
  input  logic                     retire,
  input  logic                     Jump,
  input  logic                     Branch,
  input  logic                     JumpSel,
  input  logic                     branch_taken,
  input  logic [31:0]              jr_target,
  output logic                     halted,
  output logic                     fault
);

  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  fetch_state_e     r_state, w_state_next;
  logic [31:0]      r_pc, w_pc_next;
  logic [31:0]      r_ir, w_ir_next;
  logic [WaitW-1:0] r_wait_cnt, w_wait_next, w_wait_inc;
  logic             r_fault, w_fault_next;

  logic [31:0]      w_pc4, w_next_pc;
  logic             w_misalign, w_is_syscall;

  fetch_sequencer_next_pc_calc u_next_pc (
    .i_pc           (r_pc),
    .i_instr_index  (r_ir[25:0]),
    .i_jump         (Jump),
    .i_jump_sel     (JumpSel),
    .i_branch       (Branch),
    .i_branch_taken (branch_taken),
    .i_jr_target    (jr_target),
    .o_pc4          (w_pc4),
    .o_next_pc      (w_next_pc),
    .o_misalign     (w_misalign)
  );

  assign w_is_syscall = (r_ir[31:26] == OpRtype) && (r_ir[5:0] == FnSyscall);
  assign w_wait_inc   = r_wait_cnt + WaitW'(1);

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    w_wait_next  = r_wait_cnt;
    w_fault_next = r_fault;
    unique case (r_state)
      StFetch: begin
        w_wait_next  = '0;
        w_state_next = StReq;
      end
      StReq: begin
        if (imem.imem_ack) begin
          w_ir_next    = imem.imem_rdata;
          w_wait_next  = '0;
          w_state_next = StIssue;
        end else if (w_wait_inc == WaitW'(MAX_WAIT)) begin
          w_fault_next = 1'b1;
          w_state_next = StHalt;
        end else begin
          w_wait_next = w_wait_inc;
        end
      end
      StIssue: begin
        if (retire) begin
          // SYSCALL and a misaligned JR both freeze pc at the offending instruction.
          if (w_is_syscall) begin
            w_state_next = StHalt;
          end else if (w_misalign) begin
            w_fault_next = 1'b1;
            w_state_next = StHalt;
          end else begin
            w_pc_next    = w_next_pc;
            w_state_next = StFetch;
          end
        end
      end
      StHalt: begin
        w_state_next = StHalt;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StFetch;
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_wait_cnt <= '0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_ir       <= w_ir_next;
      r_wait_cnt <= w_wait_next;
      r_fault    <= w_fault_next;
    end
  end

  assign imem.imem_req  = (r_state == StReq);
  assign imem.imem_addr = r_pc;
  assign issue_valid    = (r_state == StIssue);
  assign halted         = (r_state == StHalt);
  assign fault          = r_fault;

  assign opcode  = r_ir[31:26];
  assign rs      = r_ir[25:21];
  assign rt      = r_ir[20:16];
  assign rd      = r_ir[15:11];
  assign imm16   = r_ir[15:0];
  assign funct   = r_ir[5:0];
  assign link_pc = w_pc4;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: table of instructions with hand-computed fields/next PCs,
// plus hand sequences for faults, SYSCALL halt and reset mid-handshake.
module tb_fetch_sequencer;
  import fetch_sequencer_pkg::*;

  localparam int unsigned MaxWait = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm16;
  logic [31:0] link_pc;
  logic        retire, Jump, Branch, JumpSel, branch_taken;
  logic [31:0] jr_target;
  logic        halted, fault;

  int n_checks = 0;
  int n_errors = 0;

  fetch_sequencer_if imem_bus ();

  fetch_sequencer #(
    .RESET_PC (32'h0000_0000),
    .MAX_WAIT (MaxWait)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem         (imem_bus),
    .issue_valid  (issue_valid),
    .opcode       (opcode),
    .funct        (funct),
    .rs           (rs),
    .rt           (rt),
    .rd           (rd),
    .imm16        (imm16),
    .link_pc      (link_pc),
    .retire       (retire),
    .Jump         (Jump),
    .Branch       (Branch),
    .JumpSel      (JumpSel),
    .branch_taken (branch_taken),
    .jr_target    (jr_target),
    .halted       (halted),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [31:0] link;
    logic        jump;
    logic        jsel;
    logic        br;
    logic        taken;
    logic [31:0] jr;
    int          delay;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                        input logic [4:0] d, input logic [5:0] fn);
    return {OpRtype, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [31:0] jtype(input logic [5:0] op, input logic [25:0] idx);
    return {op, idx};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_req(input string name);
    int k;
    for (k = 0; k < 12; k++) begin
      if (imem_bus.imem_req === 1'b1) break;
      @(negedge clk);
    end
    chk({name, " req seen"}, 32'(imem_bus.imem_req), 32'd1);
  endtask

  task automatic clear_ctrl();
    retire = 0; Jump = 0; JumpSel = 0; Branch = 0; branch_taken = 0; jr_target = '0;
  endtask

  // Fetch one instruction at the expected address, check issued fields, then retire it.
  task automatic do_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    wait_req(tag);
    chk({tag, " addr"}, imem_bus.imem_addr, v.addr);
    for (int d = 0; d < v.delay; d++) @(negedge clk);
    if (v.delay > 0) chk({tag, " req held"}, 32'(imem_bus.imem_req), 32'd1);
    imem_bus.imem_ack = 1; imem_bus.imem_rdata = v.instr;
    @(negedge clk);
    imem_bus.imem_ack = 0; imem_bus.imem_rdata = '0;
    chk({tag, " issue_valid"}, 32'(issue_valid), 32'd1);
    chk({tag, " req dropped"}, 32'(imem_bus.imem_req), 32'd0);
    // Ack outside REQ must not disturb the IR.
    imem_bus.imem_ack = 1; imem_bus.imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    imem_bus.imem_ack = 0; imem_bus.imem_rdata = '0;
    chk({tag, " opcode"}, 32'(opcode), 32'(v.op));
    chk({tag, " funct"}, 32'(funct), 32'(v.fn));
    chk({tag, " rs/rt/rd"}, {17'd0, rs, rt, rd}, {17'd0, v.rs, v.rt, v.rd});
    chk({tag, " imm16"}, 32'(imm16), 32'(v.imm));
    chk({tag, " link_pc"}, link_pc, v.link);
    retire = 1; Jump = v.jump; JumpSel = v.jsel; Branch = v.br;
    branch_taken = v.taken; jr_target = v.jr;
    @(negedge clk);
    clear_ctrl();
    chk({tag, " retired"}, {30'd0, issue_valid, halted}, 32'd0);
  endtask

  // Fetch and issue one instruction without retiring it.
  task automatic fetch_issue(input string tag, input logic [31:0] exp_addr,
                             input logic [31:0] instr);
    wait_req(tag);
    chk({tag, " addr"}, imem_bus.imem_addr, exp_addr);
    imem_bus.imem_ack = 1; imem_bus.imem_rdata = instr;
    @(negedge clk);
    imem_bus.imem_ack = 0; imem_bus.imem_rdata = '0;
    chk({tag, " issue_valid"}, 32'(issue_valid), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int req_seen;
    logic [31:0] jr_i;
    jr_i = rtype(5'd31, 5'd0, 5'd0, FnJr);

    //               instr                                addr          op      fn     rs  rt  rd  imm       link          j  js br tk jr            dly
    vecs.push_back('{rtype(5'd1, 5'd2, 5'd3, FnAdd),      32'h0,        OpRtype, FnAdd, 1,  2,  3,  16'h1820, 32'h4,        0, 0, 0, 0, 32'h0,        0});
    vecs.push_back('{rtype(5'd4, 5'd5, 5'd6, FnSub),      32'h4,        OpRtype, FnSub, 4,  5,  6,  16'h3022, 32'h8,        0, 0, 0, 0, 32'h0,        3});
    vecs.push_back('{rtype(5'd7, 5'd8, 5'd9, FnSlt),      32'h8,        OpRtype, FnSlt, 7,  8,  9,  16'h482A, 32'hC,        0, 0, 0, 0, 32'h0,        0});
    vecs.push_back('{itype(OpAddi, 5'd1, 5'd2, 16'h1234), 32'hC,        OpAddi, 6'h34, 1,  2,  2,  16'h1234, 32'h10,       0, 0, 0, 0, 32'h0,        0});
    vecs.push_back('{itype(OpBne, 5'd1, 5'd2, 16'hFFFE),  32'h10,       OpBne,  6'h3E, 1,  2,  31, 16'hFFFE, 32'h14,       0, 0, 1, 1, 32'h0,        0});
    vecs.push_back('{itype(OpXori, 5'd3, 5'd4, 16'h00FF), 32'hC,        OpXori, 6'h3F, 3,  4,  0,  16'h00FF, 32'h10,       0, 1, 0, 0, 32'h999,      0});
    vecs.push_back('{itype(OpBne, 5'd1, 5'd2, 16'hFFFE),  32'h10,       OpBne,  6'h3E, 1,  2,  31, 16'hFFFE, 32'h14,       0, 0, 1, 0, 32'h0,        0});
    vecs.push_back('{itype(OpLw, 5'd29, 5'd8, 16'h0004),  32'h14,       OpLw,   6'h04, 29, 8,  0,  16'h0004, 32'h18,       0, 0, 0, 0, 32'h0,        5});
    vecs.push_back('{jr_i,                                32'h18,       OpRtype, FnJr,  31, 0,  0,  16'h0008, 32'h1C,       1, 1, 0, 0, 32'h1000_0000, 0});
    vecs.push_back('{jtype(OpJal, 26'h40),                32'h1000_0000, OpJal, 6'h00, 0,  0,  0,  16'h0040, 32'h1000_0004, 1, 0, 0, 0, 32'h0,        0});
    vecs.push_back('{itype(OpSw, 5'd2, 5'd3, 16'hFFF0),   32'h1000_0100, OpSw,  6'h30, 2,  3,  31, 16'hFFF0, 32'h1000_0104, 0, 0, 0, 0, 32'h0,        0});
    vecs.push_back('{jr_i,                                32'h1000_0104, OpRtype, FnJr, 31, 0,  0,  16'h0008, 32'h1000_0108, 1, 1, 0, 0, 32'h1000_0000, 0});
    vecs.push_back('{jtype(OpJ, 26'h40),                  32'h1000_0000, OpJ,   6'h00, 0,  0,  0,  16'h0040, 32'h1000_0004, 1, 0, 0, 0, 32'h0,        0});
    vecs.push_back('{jr_i,                                32'h1000_0100, OpRtype, FnJr, 31, 0,  0,  16'h0008, 32'h1000_0104, 1, 1, 0, 0, 32'h200,      0});
    vecs.push_back('{jtype(OpJ, 26'h100),                 32'h200,      OpJ,    6'h00, 0,  0,  0,  16'h0100, 32'h204,      1, 0, 1, 1, 32'h0,        0});
    vecs.push_back('{rtype(5'd1, 5'd2, 5'd3, FnAdd),      32'h400,      OpRtype, FnAdd, 1,  2,  3,  16'h1820, 32'h404,      0, 0, 0, 0, 32'h0,        0});
    vecs.push_back('{jr_i,                                32'h404,      OpRtype, FnJr,  31, 0,  0,  16'h0008, 32'h408,      1, 1, 0, 0, 32'hFFFF_FFFC, 0});
    vecs.push_back('{rtype(5'd1, 5'd2, 5'd3, FnAdd),      32'hFFFF_FFFC, OpRtype, FnAdd, 1, 2,  3,  16'h1820, 32'h0,        0, 0, 0, 0, 32'h0,        0});
    vecs.push_back('{rtype(5'd7, 5'd8, 5'd9, FnSlt),      32'h0,        OpRtype, FnSlt, 7,  8,  9,  16'h482A, 32'h4,        0, 0, 0, 0, 32'h0,        0});

    imem_bus.imem_ack = 0; imem_bus.imem_rdata = '0;
    clear_ctrl();

    // Reset state.
    reset = 1;
    @(negedge clk);
    @(negedge clk);
    chk("reset req", 32'(imem_bus.imem_req), 32'd0);
    chk("reset flags", {29'd0, issue_valid, halted, fault}, 32'd0);
    chk("reset IR", {opcode, funct, imm16, 4'd0}, 32'd0);
    chk("reset addr", imem_bus.imem_addr, 32'h0);
    chk("reset link_pc", link_pc, 32'h4);
    reset = 0;

    foreach (vecs[i]) do_vec(i, vecs[i]);

    // Misaligned JR target: fault, halt, pc frozen, no more requests.
    fetch_issue("jrmis", 32'h4, jr_i);
    retire = 1; Jump = 1; JumpSel = 1; jr_target = 32'h202;
    @(negedge clk);
    clear_ctrl();
    chk("jrmis flags", {30'd0, fault, halted}, 32'd3);
    req_seen = 0;
    for (int c = 0; c < 10; c++) begin
      if (imem_bus.imem_req !== 1'b0) req_seen++;
      @(negedge clk);
    end
    chk("jrmis no req", 32'(req_seen), 32'd0);
    chk("jrmis pc", imem_bus.imem_addr, 32'h4);

    // Timeout: MAX_WAIT request cycles without ack.
    do_reset();
    wait_req("tmo");
    repeat (MaxWait - 1) @(negedge clk);
    chk("tmo before", {30'd0, imem_bus.imem_req, fault}, 32'd2);
    @(negedge clk);
    chk("tmo after", {29'd0, imem_bus.imem_req, fault, halted}, 32'd3);

    // SYSCALL halts without fault; retire while in REQ is ignored.
    do_reset();
    wait_req("sys0");
    retire = 1; Jump = 1; JumpSel = 1; jr_target = 32'h300;
    @(negedge clk);
    clear_ctrl();
    chk("retire in REQ", {30'd0, imem_bus.imem_req, issue_valid}, 32'd2);
    fetch_issue("sys0", 32'h0, rtype(5'd1, 5'd2, 5'd3, FnAdd));
    retire = 1;
    @(negedge clk);
    clear_ctrl();
    fetch_issue("sys1", 32'h4, 32'h0000_000C);
    retire = 1;
    @(negedge clk);
    clear_ctrl();
    chk("sys flags", {29'd0, halted, fault, issue_valid}, 32'd4);
    req_seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 3) begin imem_bus.imem_ack = 1; retire = 1; end
      if (c == 4) begin imem_bus.imem_ack = 0; retire = 0; end
      if (imem_bus.imem_req !== 1'b0) req_seen++;
      @(negedge clk);
    end
    chk("sys no req", 32'(req_seen), 32'd0);
    chk("sys pc", imem_bus.imem_addr, 32'h4);
    chk("sys still halted", 32'(halted), 32'd1);
    do_reset();
    wait_req("sys rst");
    chk("sys rst addr", imem_bus.imem_addr, 32'h0);

    // Reset in REQ with ack in the same cycle: IR stays cleared, pc back to reset value.
    fetch_issue("rreq", 32'h0, rtype(5'd1, 5'd2, 5'd3, FnAdd));
    retire = 1;
    @(negedge clk);
    clear_ctrl();
    wait_req("rreq2");
    chk("rreq2 addr", imem_bus.imem_addr, 32'h4);
    reset = 1; imem_bus.imem_ack = 1; imem_bus.imem_rdata = 32'h1234_5678;
    @(negedge clk);
    reset = 0; imem_bus.imem_ack = 0; imem_bus.imem_rdata = '0;
    chk("rreq state", {30'd0, issue_valid, imem_bus.imem_req}, 32'd0);
    chk("rreq IR", {opcode, imm16, 10'd0}, 32'd0);
    chk("rreq pc", imem_bus.imem_addr, 32'h0);
    wait_req("rreq3");
    chk("rreq3 addr", imem_bus.imem_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
